temperature_scan_controller: RTL and testbench

Round-robin scheduler that shares one combinational TemperatureAnalyzer between N_CH patient temperature channels. It accepts samples from each channel over a valid/ack handshake, drives the selected 8-bit temperature onto the analyzer input and captures the abnormality flag. It keeps per-channel consecutive-abnormal and consecutive-normal counters and raises or clears a per-channel alarm with hysteresis. It sits between the sensor front-ends and the alarm/display logic of the health-care system.

---
 rtl/temperature_scan_controller.sv | 117 +++++++++++
 tb/tb_temperature_scan_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/temperature_scan_controller.sv
// temperature_scan_controller: round-robin sharing of one temperature analyzer across
// N_CH channels, with per-channel alarm hysteresis.
module temperature_scan_controller #(
    parameter int N_CH        = 4,
    parameter int ALARM_COUNT = 3,
    parameter int CLEAR_COUNT = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N_CH-1:0]     sample_valid_i,
    input  logic [8*N_CH-1:0]   sample_temp_i,
    output logic [N_CH-1:0]     sample_ack_o,
    output logic [7:0]          ana_temperature_o,
    input  logic                ana_abnormality_i,
    output logic [N_CH-1:0]     alarm_o,
    output logic [2:0]          last_channel_o,
    output logic                busy_o
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, UPDATE} state_t;
    state_t          state_q;
    logic [2:0]      grant_q, grant_d, last_q;
    logic            abn_q, busy_q, found;
    logic [7:0]      ana_q;
    logic [3:0]      cand, abn_inc, norm_inc;
    logic            clr;
    logic [N_CH-1:0] ack_q, alarm_q, alarm_d;
    logic [3:0]      abn_cnt_q [N_CH];
    logic [3:0]      norm_cnt_q [N_CH];
    logic [3:0]      abn_cnt_d [N_CH];
    logic [3:0]      norm_cnt_d [N_CH];
    logic [7:0]      valid_pad;
    logic [63:0]     temp_pad;
    // Padding to 8 channels keeps the 3-bit grant a legal index for any N_CH.
    assign valid_pad = 8'(sample_valid_i);
    assign temp_pad  = 64'(sample_temp_i);
    always_comb begin
        grant_d = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = {1'b0, last_q} + 4'(k);
            cand = (cand >= 4'(N_CH)) ? cand - 4'(N_CH) : cand;
            if (!found && valid_pad[cand[2:0]]) begin
                found   = 1'b1;
                grant_d = cand[2:0];
            end
        end
    end
    // Next counter/alarm values for every channel as if it were the one granted.
    always_comb begin
        abn_inc    = '0;
        norm_inc   = '0;
        clr        = 1'b0;
        alarm_d    = '0;
        abn_cnt_d  = '{default: '0};
        norm_cnt_d = '{default: '0};
        for (int i = 0; i < N_CH; i++) begin
            abn_inc       = (abn_cnt_q[i] >= 4'(ALARM_COUNT)) ? 4'(ALARM_COUNT) : abn_cnt_q[i] + 4'd1;
            norm_inc      = (norm_cnt_q[i] >= 4'(CLEAR_COUNT)) ? 4'(CLEAR_COUNT) : norm_cnt_q[i] + 4'd1;
            clr           = !abn_q && alarm_q[i] && (norm_inc >= 4'(CLEAR_COUNT));
            abn_cnt_d[i]  = abn_q ? abn_inc : 4'd0;
            norm_cnt_d[i] = (abn_q || clr) ? 4'd0 : norm_inc;
            alarm_d[i]    = abn_q ? (alarm_q[i] || (abn_inc >= 4'(ALARM_COUNT))) : (alarm_q[i] && !clr);
        end
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 3'(N_CH - 1);
            abn_q   <= 1'b0;
            busy_q  <= 1'b0;
            ana_q   <= '0;
            ack_q   <= '0;
            alarm_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                abn_cnt_q[i]  <= '0;
                norm_cnt_q[i] <= '0;
            end
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|sample_valid_i) begin
                        grant_q <= grant_d;
                        ana_q   <= temp_pad[{grant_d, 3'b000} +: 8];
                        busy_q  <= 1'b1;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: state_q <= CHECK;
                CHECK: begin
                    abn_q <= ana_abnormality_i;
                    for (int i = 0; i < N_CH; i++) ack_q[i] <= (3'(i) == grant_q);
                    state_q <= UPDATE;
                end
                default: begin
                    last_q <= grant_q;
                    for (int i = 0; i < N_CH; i++) begin
                        if (3'(i) == grant_q) begin
                            alarm_q[i]    <= alarm_d[i];
                            abn_cnt_q[i]  <= abn_cnt_d[i];
                            norm_cnt_q[i] <= norm_cnt_d[i];
                        end
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign sample_ack_o      = ack_q;
    assign ana_temperature_o = ana_q;
    assign alarm_o           = alarm_q;
    assign last_channel_o    = last_q;
    assign busy_o            = busy_q;
endmodule

// File: tb/tb_temperature_scan_controller.sv
// tb_temperature_scan_controller: randomized sources with a scoreboard; a monitor checks
// grant order, timing, analyzer drive and alarm hysteresis against a behavioural model.
module tb_temperature_scan_controller;
    localparam int N = 4, A = 3, C = 2;
    logic         clk = 1'b0, rst = 1'b1;
    logic [N-1:0] valid = '0;
    logic [8*N-1:0] temp = '0;
    logic [N-1:0] ack, alarm;
    logic [7:0]   ana;
    logic         abn, busy;
    logic [2:0]   last;

    temperature_scan_controller #(.N_CH(N), .ALARM_COUNT(A), .CLEAR_COUNT(C)) dut (
        .clk_i(clk), .reset_i(rst), .sample_valid_i(valid), .sample_temp_i(temp),
        .sample_ack_o(ack), .ana_temperature_o(ana), .ana_abnormality_i(abn),
        .alarm_o(alarm), .last_channel_o(last), .busy_o(busy)
    );

    always #5 clk = ~clk;
    assign abn = (ana < 8'd35) || (ana > 8'd37);

    typedef struct { logic [7:0] t; logic alarm; } exp_t;
    exp_t         exp_q [N][$];
    logic [7:0]   src_q [N][$];
    int           checks = 0, errors = 0;
    int           m_abn [N], m_norm [N];
    logic [N-1:0] m_alarm = '0;
    bit           rand_gap = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Sources: drop valid on the ack cycle, present the next sample from the following cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < N; ch++) begin
                if (valid[ch] && ack[ch]) valid[ch] = 1'b0;
                else if (!valid[ch] && src_q[ch].size() > 0 && (!rand_gap || $urandom_range(0, 2) == 0)) begin
                    logic [7:0] t;
                    bit a;
                    t = src_q[ch].pop_front();
                    temp[ch*8 +: 8] = t;
                    valid[ch] = 1'b1;
                    a = (t < 8'd35) || (t > 8'd37);
                    if (a) begin
                        m_abn[ch]++;
                        m_norm[ch] = 0;
                        if (m_abn[ch] >= A) m_alarm[ch] = 1'b1;
                    end else begin
                        m_abn[ch] = 0;
                        m_norm[ch]++;
                        if (m_alarm[ch] && m_norm[ch] >= C) m_alarm[ch] = 1'b0;
                    end
                    exp_q[ch].push_back('{t: t, alarm: m_alarm[ch]});
                end
            end
        end
    end

    int           cyc = 0, next_idle = 0, last_ch = N - 1, ack_cnt = 0;
    logic [N-1:0] vhist [int];
    logic [N-1:0] exp_alarm_vec = '0;
    bit           chk_after = 1'b0;

    always @(posedge clk) begin
        vhist[cyc] = valid;
        cyc++;
    end

    always @(negedge clk) begin
        int ch, g, exp_ch;
        logic [N-1:0] v;
        exp_t e;
        if (!rst) begin
            if (chk_after) begin
                chk_after = 1'b0;
                check("alarm_vector", int'(alarm), int'(exp_alarm_vec));
                check("last_channel", int'(last), last_ch);
                check("busy_in_idle", int'(busy), 0);
            end
            if (ack != '0) begin
                ack_cnt++;
                check("ack_onehot", $countones(ack), 1);
                ch = 0;
                for (int i = N - 1; i >= 0; i--) if (ack[i]) ch = i;
                g = next_idle;
                while (g < cyc - 3 && vhist[g] == '0) g++;
                check("grant_cycle", cyc - 3, g);
                v = vhist[cyc-3];
                exp_ch = -1;
                for (int k = 1; k <= N; k++) if (exp_ch < 0 && v[(last_ch + k) % N]) exp_ch = (last_ch + k) % N;
                check("grant_channel", ch, exp_ch);
                check("busy_in_update", int'(busy), 1);
                check("ack_expected", int'(exp_q[ch].size() > 0), 1);
                if (exp_q[ch].size() > 0) begin
                    e = exp_q[ch].pop_front();
                    check("ana_temperature", int'(ana), int'(e.t));
                    exp_alarm_vec[ch] = e.alarm;
                end
                last_ch = ch;
                next_idle = cyc + 1;
                chk_after = 1'b1;
            end
        end
    end

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 4000 && !done; n++) begin
            @(negedge clk);
            done = (valid == '0) && !busy;
            for (int ch = 0; ch < N; ch++) done = done && src_q[ch].size() == 0 && exp_q[ch].size() == 0;
        end
        check("drain_done", int'(done), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_checks();
        check("rst_ack", int'(ack), 0);
        check("rst_ana", int'(ana), 0);
        check("rst_alarm", int'(alarm), 0);
        check("rst_last", int'(last), N - 1);
        check("rst_busy", int'(busy), 0);
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            m_abn[ch] = 0;
            m_norm[ch] = 0;
        end
        m_alarm = '0;
    endtask

    initial begin
        int base;
        model_reset();
        repeat (2) @(negedge clk);
        reset_checks();
        rst = 1'b0;
        next_idle = cyc;

        src_q[0].push_back(8'd36);
        drain();
        check("t1_alarm", int'(alarm), 0);
        check("t1_last", int'(last), 0);

        for (int i = 0; i < 3; i++) src_q[1].push_back(8'd2);
        drain();
        check("t2_alarm", int'(alarm), 'b0010);

        src_q[1].push_back(8'd36);
        src_q[1].push_back(8'd2);
        src_q[1].push_back(8'd36);
        src_q[1].push_back(8'd36);
        drain();
        check("t3_alarm", int'(alarm), 0);

        base = ack_cnt;
        for (int i = 0; i < 3; i++) for (int ch = 0; ch < N; ch++) src_q[ch].push_back(8'd36);
        drain();
        check("t4_ack_count", ack_cnt - base, 3 * N);

        model_reset();
        src_q[2].push_back(8'd40);
        for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
        check("t5_in_drive", int'(busy), 1);
        #1 rst = 1'b1;
        #1 reset_checks();
        repeat (2) begin
            @(negedge clk);
            check("t5_no_ack_in_reset", int'(ack), 0);
        end
        rst = 1'b0;
        last_ch = N - 1;
        next_idle = cyc;
        exp_alarm_vec = '0;
        chk_after = 1'b0;
        drain();
        check("t5_last", int'(last), 2);

        for (int i = 0; i < 10; i++) src_q[3].push_back((i % 2 == 0) ? 8'd2 : 8'd36);
        drain();
        check("t6_alarm", int'(alarm), 0);

        rand_gap = 1'b1;
        for (int i = 0; i < 200; i++) src_q[$urandom_range(0, N - 1)].push_back(8'($urandom_range(30, 42)));
        drain();
        check("rand_alarm_final", int'(alarm), int'(m_alarm));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
